// File: rtl/vga_timing_pkg.sv
// Shared types, state encoding and timing helpers for the parametrised VGA timing generator.
package vga_timing_pkg;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic blank_n;
    logic end_of_line;
    logic end_of_frame;
    logic valid;
  } vga_timing_t;

  typedef enum logic [1:0] {
    ST_STOPPED  = 2'd0,
    ST_RUNNING  = 2'd1,
    ST_STOPPING = 2'd2
  } run_state_t;

  // Standard 640x480@60 timing (25.175 MHz pixel clock)
  localparam int VGA640_H_VISIBLE = 640;
  localparam int VGA640_H_FRONT   = 16;
  localparam int VGA640_H_SYNC    = 96;
  localparam int VGA640_H_BACK    = 48;
  localparam int VGA640_V_VISIBLE = 480;
  localparam int VGA640_V_FRONT   = 10;
  localparam int VGA640_V_SYNC    = 2;
  localparam int VGA640_V_BACK    = 33;

  function automatic int axis_total(input int visible, input int front,
                                    input int sync, input int back);
    return visible + front + sync + back;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: position register holding the next position to emit, with
// wrap, sync pin level and visible-region decode of that position.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int VISIBLE = 640,
  parameter int FRONT   = 16,
  parameter int SYNC    = 96,
  parameter int BACK    = 48,
  parameter bit POL     = 1'b0,
  localparam int TOTAL  = axis_total(VISIBLE, FRONT, SYNC, BACK),
  localparam int W      = $clog2(TOTAL)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         step,
  input  logic         clear,
  output logic [W-1:0] position,
  output logic         wrap,
  output logic         sync,
  output logic         visible
);

  logic [W-1:0] pos;
  logic [31:0]  pos_ext;
  logic         in_sync;

  // Position advances on step, wraps at TOTAL-1, and is forced to 0 by clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos <= '0;
    end else if (clear) begin
      pos <= '0;
    end else if (step) begin
      pos <= wrap ? '0 : pos + W'(1);
    end else begin
      pos <= pos;
    end
  end

  // Compare in 32 bits so a zero-length back porch cannot overflow the bound.
  assign pos_ext  = 32'(pos);
  assign in_sync  = (pos_ext >= 32'(VISIBLE + FRONT)) && (pos_ext < 32'(VISIBLE + FRONT + SYNC));
  assign sync     = in_sync ? POL : ~POL;
  assign visible  = (pos_ext < 32'(VISIBLE));
  assign wrap     = (pos_ext == 32'(TOTAL - 1));
  assign position = pos;

endmodule

// File: rtl/vga_timing_gen_param.sv
// Parametrised VGA timing generator with coordinates, line prefetch and frame-aligned stop.
// Optional feature macro: VGA_TIMING_GEN_LINE_DOUBLE_EN (line doubling, adds src_line_o).
module vga_timing_gen_param
  import vga_timing_pkg::*;
#(
  parameter int CLK_DIV       = 1,
  parameter int H_VISIBLE     = VGA640_H_VISIBLE,
  parameter int H_FRONT       = VGA640_H_FRONT,
  parameter int H_SYNC        = VGA640_H_SYNC,
  parameter int H_BACK        = VGA640_H_BACK,
  parameter int V_VISIBLE     = VGA640_V_VISIBLE,
  parameter int V_FRONT       = VGA640_V_FRONT,
  parameter int V_SYNC        = VGA640_V_SYNC,
  parameter int V_BACK        = VGA640_V_BACK,
  parameter bit HSYNC_POL     = 1'b0,
  parameter bit VSYNC_POL     = 1'b0,
  parameter int PREFETCH_LEAD = 8,
  localparam int H_TOTAL      = axis_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK),
  localparam int V_TOTAL      = axis_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK),
  localparam int X_W          = $clog2(H_TOTAL),
  localparam int Y_W          = $clog2(V_TOTAL),
  localparam int L_W          = $clog2(V_VISIBLE)
`ifdef VGA_TIMING_GEN_LINE_DOUBLE_EN
  , localparam int S_W        = $clog2(V_VISIBLE / 2)
`endif
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           enable_i,
  output vga_timing_t    timing_o,
  output logic [X_W-1:0] x_o,
  output logic [Y_W-1:0] y_o,
  output logic           line_req_o,
  output logic [L_W-1:0] line_idx_o,
`ifdef VGA_TIMING_GEN_LINE_DOUBLE_EN
  output logic [S_W-1:0] src_line_o,
`endif
  output logic           running_o
);

  localparam int P_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  if (PREFETCH_LEAD < 1 || PREFETCH_LEAD > H_TOTAL - H_VISIBLE) begin : g_bad_lead
    $error("PREFETCH_LEAD must lie in 1..H_TOTAL-H_VISIBLE");
  end
  if (CLK_DIV < 1) begin : g_bad_div
    $error("CLK_DIV must be at least 1");
  end
`ifdef VGA_TIMING_GEN_LINE_DOUBLE_EN
  if ((V_VISIBLE % 2) != 0) begin : g_bad_double
    $error("line doubling needs an even V_VISIBLE");
  end
`endif

  run_state_t     state;
  run_state_t     state_next;
  logic [P_W-1:0] presc;
  logic           tick;
  logic           clear;
  logic [X_W-1:0] h_pos;
  logic [Y_W-1:0] v_pos;
  logic           h_wrap, v_wrap, h_sync, v_sync, h_vis, v_vis;
  logic           eol, eof, req_line, req;
  logic [L_W-1:0] idx;
  int             next_line;

  assign tick  = (state != ST_STOPPED) && (presc == '0);
  assign clear = (state == ST_STOPPED);

  vga_axis_counter #(
    .VISIBLE(H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK), .POL(HSYNC_POL)
  ) u_h_axis (
    .clk(clk_i), .rst(rst_i), .step(tick), .clear(clear),
    .position(h_pos), .wrap(h_wrap), .sync(h_sync), .visible(h_vis)
  );

  vga_axis_counter #(
    .VISIBLE(V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK), .POL(VSYNC_POL)
  ) u_v_axis (
    .clk(clk_i), .rst(rst_i), .step(tick && h_wrap), .clear(clear),
    .position(v_pos), .wrap(v_wrap), .sync(v_sync), .visible(v_vis)
  );

  // Run-state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ST_STOPPED;
    end else begin
      state <= state_next;
    end
  end

  // Stopping only completes on the tick that emits the last position of a frame.
  always_comb begin
    state_next = state;
    case (state)
      ST_STOPPED:  if (enable_i) state_next = ST_RUNNING; else state_next = ST_STOPPED;
      ST_RUNNING:  if (enable_i) state_next = ST_RUNNING; else state_next = ST_STOPPING;
      ST_STOPPING: begin
        if (enable_i) begin
          state_next = ST_RUNNING;
        end else if (tick && h_wrap && v_wrap) begin
          state_next = ST_STOPPED;
        end else begin
          state_next = ST_STOPPING;
        end
      end
      default:     state_next = ST_STOPPED;
    endcase
  end

  // Pixel prescaler; held at 0 while stopped so a start ticks immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      presc <= '0;
    end else if (state == ST_STOPPED) begin
      presc <= '0;
    end else if (tick) begin
      presc <= P_W'(CLK_DIV - 1);
    end else begin
      presc <= presc - P_W'(1);
    end
  end

  // Event and prefetch decode on the lookahead position.
  always_comb begin
    eol       = (int'(h_pos) == H_VISIBLE) && v_vis;
    eof       = eol && (int'(v_pos) == V_VISIBLE - 1);
    if (v_wrap) begin
      next_line = 0;
    end else begin
      next_line = int'(v_pos) + 1;
    end
    req_line  = (int'(h_pos) == H_TOTAL - PREFETCH_LEAD) && (v_wrap || int'(v_pos) < V_VISIBLE - 1);
`ifdef VGA_TIMING_GEN_LINE_DOUBLE_EN
    req       = req_line && ((next_line % 2) == 0);
    idx       = L_W'(next_line / 2);
`else
    req       = req_line;
    idx       = L_W'(next_line);
`endif
  end

  // Output register: one position per tick; pulses last exactly one cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      timing_o.hsync        <= ~HSYNC_POL;
      timing_o.vsync        <= ~VSYNC_POL;
      timing_o.blank_n      <= 1'b0;
      timing_o.end_of_line  <= 1'b0;
      timing_o.end_of_frame <= 1'b0;
      timing_o.valid        <= 1'b0;
      x_o                   <= '0;
      y_o                   <= '0;
      line_req_o            <= 1'b0;
      line_idx_o            <= '0;
`ifdef VGA_TIMING_GEN_LINE_DOUBLE_EN
      src_line_o            <= '0;
`endif
      running_o             <= 1'b0;
    end else begin
      running_o <= (state_next != ST_STOPPED);
      if (tick) begin
        timing_o.hsync        <= h_sync;
        timing_o.vsync        <= v_sync;
        timing_o.blank_n      <= h_vis && v_vis;
        timing_o.end_of_line  <= eol;
        timing_o.end_of_frame <= eof;
        timing_o.valid        <= 1'b1;
        x_o                   <= h_pos;
        y_o                   <= v_pos;
        line_req_o            <= req;
        if (req) line_idx_o <= idx;
`ifdef VGA_TIMING_GEN_LINE_DOUBLE_EN
        if (v_vis) src_line_o <= S_W'(v_pos >> 1);
`endif
      end else begin
        timing_o.end_of_line  <= 1'b0;
        timing_o.end_of_frame <= 1'b0;
        timing_o.valid        <= 1'b0;
        line_req_o            <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen_param.sv
// Directed bench for vga_timing_gen_param on a 16x8 total timing with CLK_DIV=2, lead 4.
module tb_vga_timing_gen_param;
  import vga_timing_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  vga_timing_t timing;
  logic [3:0]  x;
  logic [2:0]  y;
  logic        req;
  logic [1:0]  idx;
  logic        running;
`ifdef VGA_TIMING_GEN_LINE_DOUBLE_EN
  logic [0:0]  src;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int prev_cyc = -1;
  int ex, ey, exp_idx, exp_src;
  int n_blank, n_eol, n_eof, n_req, quiet_err;
  vga_timing_t rst_exp;

  vga_timing_gen_param #(
    .CLK_DIV(2), .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .PREFETCH_LEAD(4)
  ) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(en), .timing_o(timing),
    .x_o(x), .y_o(y), .line_req_o(req), .line_idx_o(idx),
`ifdef VGA_TIMING_GEN_LINE_DOUBLE_EN
    .src_line_o(src),
`endif
    .running_o(running)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Wait for n valids, checking each one against the hand-derived timing rules.
  task automatic run_positions(input int n);
    bit got;
    bit hs_e, vs_e, bl_e, eol_e, eof_e, req_e;
    int idx_e;
    for (int i = 0; i < n; i++) begin
      got = 1'b0;
      for (int c = 0; c < 8 && !got; c++) begin
        @(negedge clk);
        if (timing.valid) got = 1'b1;
        else if (timing.end_of_line || timing.end_of_frame || req) quiet_err++;
      end
      checks++;
      if (!got) begin
        errors++;
        $display("FAIL valid_timeout: got no valid, want valid at (%0d,%0d)", ex, ey);
        return;
      end
      if (prev_cyc >= 0) begin
        checks++;
        if (cyc - prev_cyc != 2) begin
          errors++;
          $display("FAIL spacing at (%0d,%0d): got %0d cycles, want 2", ex, ey, cyc - prev_cyc);
        end
      end
      prev_cyc = cyc;
      hs_e  = !(ex >= 10 && ex <= 12);
      vs_e  = !(ey >= 5 && ey <= 6);
      bl_e  = (ex < 8) && (ey < 4);
      eol_e = (ex == 8) && (ey < 4);
      eof_e = (ex == 8) && (ey == 3);
`ifdef VGA_TIMING_GEN_LINE_DOUBLE_EN
      req_e = (ex == 12) && (ey == 7 || ey == 1);
      idx_e = (ey == 7) ? 0 : (ey + 1) / 2;
      if (ey < 4) exp_src = ey / 2;
`else
      req_e = (ex == 12) && (ey == 7 || ey < 3);
      idx_e = (ey == 7) ? 0 : ey + 1;
`endif
      if (req_e) exp_idx = idx_e;
      checks += 8;
      if (x !== 4'(ex) || y !== 3'(ey)) begin
        errors++; $display("FAIL pos: got (%0d,%0d) want (%0d,%0d)", x, y, ex, ey);
      end
      if (timing.hsync !== hs_e) begin
        errors++; $display("FAIL hsync at (%0d,%0d): got %b want %b", ex, ey, timing.hsync, hs_e);
      end
      if (timing.vsync !== vs_e) begin
        errors++; $display("FAIL vsync at (%0d,%0d): got %b want %b", ex, ey, timing.vsync, vs_e);
      end
      if (timing.blank_n !== bl_e) begin
        errors++; $display("FAIL blank_n at (%0d,%0d): got %b want %b", ex, ey, timing.blank_n, bl_e);
      end
      if (timing.end_of_line !== eol_e) begin
        errors++; $display("FAIL eol at (%0d,%0d): got %b want %b", ex, ey, timing.end_of_line, eol_e);
      end
      if (timing.end_of_frame !== eof_e) begin
        errors++; $display("FAIL eof at (%0d,%0d): got %b want %b", ex, ey, timing.end_of_frame, eof_e);
      end
      if (req !== req_e) begin
        errors++; $display("FAIL line_req at (%0d,%0d): got %b want %b", ex, ey, req, req_e);
      end
      if (idx !== 2'(exp_idx)) begin
        errors++; $display("FAIL line_idx at (%0d,%0d): got %0d want %0d", ex, ey, idx, exp_idx);
      end
`ifdef VGA_TIMING_GEN_LINE_DOUBLE_EN
      checks++;
      if (src !== 1'(exp_src)) begin
        errors++; $display("FAIL src_line at (%0d,%0d): got %0d want %0d", ex, ey, src, exp_src);
      end
`endif
      n_blank += int'(timing.blank_n);
      n_eol   += int'(timing.end_of_line);
      n_eof   += int'(timing.end_of_frame);
      n_req   += int'(req);
      ex++;
      if (ex == 16) begin
        ex = 0;
        ey = (ey == 7) ? 0 : ey + 1;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b0;
    repeat (3) @(negedge clk);
    checks += 3;
    if (timing !== rst_exp) begin
      errors++; $display("FAIL reset_timing: got %b want %b", timing, rst_exp);
    end
    if (x !== 4'd0 || y !== 3'd0 || idx !== 2'd0) begin
      errors++; $display("FAIL reset_coords: got x=%0d y=%0d idx=%0d want 0", x, y, idx);
    end
    if (req !== 1'b0 || running !== 1'b0) begin
      errors++; $display("FAIL reset_ctrl: got req=%b running=%b want 0", req, running);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (timing.valid !== 1'b0 || running !== 1'b0) begin
      errors++; $display("FAIL idle_stopped: got valid=%b running=%b want 0", timing.valid, running);
    end
    exp_idx = 0; exp_src = 0;
  endtask

  task automatic test_start;
    int t0;
    ex = 0; ey = 0; prev_cyc = -1;
    en = 1'b1; t0 = cyc;
    run_positions(1);
    checks += 2;
    if (prev_cyc - t0 != 2) begin
      errors++; $display("FAIL start_latency: got %0d cycles want 2", prev_cyc - t0);
    end
    if (running !== 1'b1) begin
      errors++; $display("FAIL running_after_start: got %b want 1", running);
    end
  endtask

  task automatic test_frame;
    run_positions(127);
    n_blank = 0; n_eol = 0; n_eof = 0; n_req = 0; quiet_err = 0;
    run_positions(128);
    checks += 5;
    if (n_blank != 32) begin errors++; $display("FAIL blank_count: got %0d want 32", n_blank); end
    if (n_eol != 4) begin errors++; $display("FAIL eol_count: got %0d want 4", n_eol); end
    if (n_eof != 1) begin errors++; $display("FAIL eof_count: got %0d want 1", n_eof); end
`ifdef VGA_TIMING_GEN_LINE_DOUBLE_EN
    if (n_req != 2) begin errors++; $display("FAIL req_count: got %0d want 2", n_req); end
`else
    if (n_req != 4) begin errors++; $display("FAIL req_count: got %0d want 4", n_req); end
`endif
    if (quiet_err != 0) begin errors++; $display("FAIL pulse_off_valid: got %0d stray pulses want 0", quiet_err); end
  endtask

  task automatic test_stop;
    int bad;
    int t0;
    run_positions(36);
    en = 1'b0;
    @(negedge clk);
    checks++;
    if (running !== 1'b1) begin errors++; $display("FAIL running_stopping: got %b want 1", running); end
    run_positions(92);
    checks++;
    if (running !== 1'b0) begin errors++; $display("FAIL running_stopped: got %b want 0", running); end
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (timing.valid || !timing.hsync || !timing.vsync || running || x !== 4'd15 || y !== 3'd7) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL stopped_idle: got %0d bad cycles (valid=%b hs=%b vs=%b x=%0d y=%0d) want 0",
                         bad, timing.valid, timing.hsync, timing.vsync, x, y);
    end
    ex = 0; ey = 0; prev_cyc = -1;
    en = 1'b1; t0 = cyc;
    run_positions(20);
    checks++;
    if (cyc - t0 != 40) begin errors++; $display("FAIL restart_timing: got %0d cycles want 40", cyc - t0); end
  endtask

  task automatic test_back_to_back;
    en = 1'b0;
    run_positions(3);
    en = 1'b1;
    run_positions(10);
    checks++;
    if (running !== 1'b1) begin errors++; $display("FAIL running_resumed: got %b want 1", running); end
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    run_positions(4);
  endtask

  task automatic test_async_reset;
    int bad;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; exp_idx = 0; exp_src = 0;
    ex = 0; ey = 0; prev_cyc = -1;
    run_positions(22);
    #2 rst = 1'b1;
    #1;
    checks += 3;
    if (timing !== rst_exp) begin
      errors++; $display("FAIL async_reset_timing: got %b want %b", timing, rst_exp);
    end
    if (x !== 4'd0 || y !== 3'd0 || idx !== 2'd0) begin
      errors++; $display("FAIL async_reset_coords: got x=%0d y=%0d idx=%0d want 0", x, y, idx);
    end
    if (req !== 1'b0 || running !== 1'b0) begin
      errors++; $display("FAIL async_reset_ctrl: got req=%b running=%b want 0", req, running);
    end
    en = 1'b0; exp_idx = 0; exp_src = 0;
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (timing.valid || running) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL stopped_after_reset: got %0d bad cycles want 0", bad); end
    ex = 0; ey = 0; prev_cyc = -1;
    en = 1'b1;
    run_positions(1);
  endtask

  initial begin
    rst_exp = '{hsync: 1'b1, vsync: 1'b1, default: 1'b0};
    rst = 1'b1; en = 1'b0;
    n_blank = 0; n_eol = 0; n_eof = 0; n_req = 0; quiet_err = 0;
    test_reset();
    test_start();
    test_frame();
    test_stop();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen_param.md
Name: vga_timing_gen_param

Overview:
- Parametrised successor to the fixed 640x480 VGA timing generator.
- All horizontal/vertical timing, sync polarities and the pixel-clock divider are parameters.
- Adds pixel coordinate outputs, a per-line prefetch request with programmable lead, and a run/stop control that only stops on a frame boundary.
- Sits between the system clock domain logic (framebuffer fetch, line buffers) and the video DAC/pin drivers.

Parameters:
- CLK_DIV, 1, system clocks per pixel tick (1 = tick every cycle).
- H_VISIBLE, 640, visible pixels per line.
- H_FRONT, 16, horizontal front porch, in pixels.
- H_SYNC, 96, hsync width, in pixels.
- H_BACK, 48, horizontal back porch, in pixels.
- V_VISIBLE, 480, visible lines per frame.
- V_FRONT, 10, vertical front porch, in lines.
- V_SYNC, 2, vsync width, in lines.
- V_BACK, 33, vertical back porch, in lines.
- HSYNC_POL, 0, active level of hsync.
- VSYNC_POL, 0, active level of vsync.
- PREFETCH_LEAD, 8, pixel ticks between line_req_o and the first visible pixel of that line. Legal range is 1..H_TOTAL-H_VISIBLE; out-of-range values are an elaboration error.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset, asynchronous, active-high.
- enable_i  in  1  level; request to run the timing.
- timing_o  out  vga_timing_t  {hsync, vsync (pin levels), blank_n, end_of_line, end_of_frame, valid}.
- x_o  out  $clog2(H_TOTAL)  horizontal position of the current timing_o.
- y_o  out  $clog2(V_TOTAL)  vertical position of the current timing_o.
- line_req_o  out  1  one-cycle prefetch pulse.
- line_idx_o  out  $clog2(V_VISIBLE)  visible line requested by line_req_o; held between pulses.
- running_o  out  1  high in RUNNING or STOPPING.

Behaviour:
- Derived constants:
  - H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK.
  - V_TOTAL = V_VISIBLE+V_FRONT+V_SYNC+V_BACK.
- Prescaler:
  - Down-counter reloads with CLK_DIV-1 at 0 and produces tick.
  - The prescaler runs only in RUNNING/STOPPING; it is cleared to 0 in STOPPED, so the first tick comes on the first cycle after the start.
- State machine:
  - STOPPED -> RUNNING when enable_i=1; counters are (0,0).
  - RUNNING -> STOPPING when enable_i=0.
  - STOPPING -> RUNNING when enable_i=1. No discontinuity in timing.
  - STOPPING -> STOPPED on the tick emitting (H_TOTAL-1, V_TOTAL-1).
- Tick outputs:
  - Each tick registers one position. On the next clk_i edge all timing_o fields, x_o and y_o update together, and timing_o.valid=1 for exactly that one cycle.
  - Fields hold between valids. valid is 0 in STOPPED.
  - The first valid after a start carries position (0,0).
- Counters:
  - x wraps H_TOTAL-1 -> 0 and then increments y.
  - y wraps V_TOTAL-1 -> 0.
  - The next-position lookahead is precomputed one tick ahead; comparisons are done on the lookahead, not on the registered output.
- Pin levels:
  - hsync = HSYNC_POL iff H_VISIBLE+H_FRONT <= x < H_VISIBLE+H_FRONT+H_SYNC; otherwise the inactive level.
  - vsync uses the analogous rule on y and switches only where x=0.
  - blank_n = (x<H_VISIBLE && y<V_VISIBLE).
- end_of_line = 1 with the valid where x==H_VISIBLE and y<V_VISIBLE.
- end_of_frame = 1 additionally only where y==V_VISIBLE-1. Both fields are 0 on all non-valid cycles.
- Prefetch:
  - line_req_o pulses (one clk_i cycle, coincident with valid) at x==H_TOTAL-PREFETCH_LEAD.
  - For line L in 1..V_VISIBLE-1, the pulse is on line L-1.
  - For line 0, the pulse is on line V_TOTAL-1, including the very first frame only if the state is already running there.
  - line_idx_o is loaded on the same edge as the pulse.
- Reset (async assert, sync release):
  - State STOPPED, all counters 0.
  - hsync/vsync at inactive level, blank_n=0, end_of_line=0, end_of_frame=0, valid=0.
  - x_o=0, y_o=0, line_req_o=0, line_idx_o=0, running_o=0.
  - Reset mid-frame aborts immediately to these values.
- enable_i toggling within one pixel tick: only the level at each clk_i edge matters; no glitch on outputs.

Optional Feature:
- Macro: VGA_TIMING_GEN_LINE_DOUBLE_EN.
- When defined:
  - Adds output src_line_o, width $clog2(V_VISIBLE/2).
  - line_req_o fires only for even visible lines, with line_idx_o = L/2.
  - src_line_o = y>>1 during visible lines; it is held at its last value otherwise.
  - V_VISIBLE must be even.
- When not defined: no src_line_o port; line_req_o fires on every visible line as above.

Decomposition:
- Package vga_timing_pkg:
  - vga_timing_t struct.
  - function computing H_TOTAL/V_TOTAL from the parameters.
  - named constants for standard 640x480@60 timing.
- Sub-module vga_axis_counter:
  - One instance per axis.
  - Parameterised VISIBLE/FRONT/SYNC/BACK/POL.
  - Inputs: step, clear. Outputs: position, wrap, sync, visible.
  - The horizontal instance's wrap drives the vertical instance's step.

Test Plan (small config: H 8/2/3/3 -> H_TOTAL 16; V 4/1/2/1 -> V_TOTAL 8; CLK_DIV=2; PREFETCH_LEAD=4; POL=0):
- Reset, then enable_i=1 -> first valid shows x=0, y=0, blank_n=1; valids are spaced exactly 2 cycles; 128 valids per frame.
- Run frame -> hsync=0 exactly for x=10..12; vsync=0 exactly for y=5..6, switching at x=0; blank_n=1 for exactly 32 valids per frame.
- Run frame -> end_of_line at x=8 for y=0..3 only; end_of_frame only at (8,3); line_req_o at x=12 on y=7,0,1,2 with line_idx_o 0,1,2,3.
- Drop enable_i at (3,2) -> output continues to (15,7); then running_o=0, valid stays 0, hsync/vsync=1; re-enable restarts at (0,0). Re-enable during STOPPING -> no gap in valid spacing.
- Assert rst_i asynchronously mid-line at (5,1) -> all outputs take reset values before the next clk_i edge; state is STOPPED.
- With VGA_TIMING_GEN_LINE_DOUBLE_EN -> line_req_o only before y=0 and y=2, with line_idx_o 0 and 1; src_line_o = 0,0,1,1 over y=0..3.
